// File: rtl/ifu_axi_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encoding, AXI field constants and the nop used to replace faulting fetches.
package ifu_axi_fetch_pkg;

  localparam int IFU_ADDR_W = 32;
  localparam int IFU_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_4B    = 3'b010;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

endpackage

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch: one PC in, one single-beat AXI4 read, word held until the idu takes it.
// Optional YSYX_23060251_IFU_ERR_EN adds err_o and turns error responses into a nop.
module ifu_axi_fetch
  import ifu_axi_fetch_pkg::*;
#(
  parameter int         ADDR_W = IFU_ADDR_W,
  parameter int         DATA_W = IFU_DATA_W,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [3:0]        arid_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic [3:0]        rid_i,
`ifdef YSYX_23060251_IFU_ERR_EN
  output logic              err_o,
`endif
  output logic              busy_o
);

  ifu_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [31:0]       inst_q;
  logic [31:0]       inst_d;
  logic              pc_ready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              inst_valid_q;
  logic              busy_q;
  logic              discard_q;
  logic              rerr_d;
  logic              beat_last;
  logic              drop_beat;
  logic              unused_ok;

  assign beat_last = rvalid_i && rlast_i;
  // A flush landing on the final beat drops it just like an earlier flush would.
  assign drop_beat = discard_q || flush_i;

`ifdef YSYX_23060251_IFU_ERR_EN
  logic err_q;
  assign rerr_d    = (rresp_i != RESP_OKAY);
  assign err_o     = err_q;
  assign unused_ok = ^rid_i;
`else
  assign rerr_d    = 1'b0;
  assign unused_ok = ^{rid_i, rresp_i};
`endif

  assign inst_d = rerr_d ? INST_NOP : rdata_i[31:0];

  assign arid_o    = AXI_ID;
  assign arlen_o   = 8'd0;
  assign arsize_o  = SIZE_4B;
  assign arburst_o = BURST_INCR;
  assign araddr_o  = {pc_q[ADDR_W-1:2], 2'b00};

  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign busy_o       = busy_q;
  // OUT can take the next PC in the same cycle the idu drains the current word.
  assign pc_ready_o   = !flush_i && (pc_ready_q || (state_q == S_OUT && inst_ready_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      pc_ready_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      discard_q    <= 1'b0;
`ifdef YSYX_23060251_IFU_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush_i && pc_valid_i) begin
            pc_q       <= pc_i;
            state_q    <= S_AR;
            pc_ready_q <= 1'b0;
            arvalid_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            pc_ready_q <= 1'b1;
          end
        end
        S_AR: begin
          // The request must complete once offered; a flush only marks the reply as dead.
          if (flush_i) discard_q <= 1'b1;
          if (arready_i) begin
            state_q   <= S_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_R: begin
          if (beat_last) begin
            rready_q <= 1'b0;
            if (drop_beat) begin
              discard_q  <= 1'b0;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              pc_ready_q <= 1'b1;
            end else begin
              inst_q       <= inst_d;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= S_OUT;
`ifdef YSYX_23060251_IFU_ERR_EN
              err_q        <= rerr_d;
`endif
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (flush_i || (inst_ready_i && !pc_valid_i)) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            pc_ready_q   <= 1'b1;
          end else if (inst_ready_i) begin
            inst_valid_q <= 1'b0;
            pc_q         <= pc_i;
            state_q      <= S_AR;
            arvalid_q    <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Bench for ifu_axi_fetch: latency table, directed flush/reset sequences, then randomized
// traffic scored against a queue-based model of which PCs must come out and with what word.
module tb_ifu_axi_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic [31:0] pc_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        rlast_i = 1'b0;
  logic [3:0]  rid_i = '0;
  logic        busy_o;
`ifdef YSYX_23060251_IFU_ERR_EN
  logic        err_o;
`endif

  ifu_axi_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o), .pc_i(pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .arid_o(arid_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
    .rresp_i(rresp_i), .rlast_i(rlast_i), .rid_i(rid_i),
`ifdef YSYX_23060251_IFU_ERR_EN
    .err_o(err_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [1:0]  resp;
    int          arw;
    int          rw;
    int          stall;
    int          lat;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic consume();
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
  endtask

  // Plays the AXI slave with fixed wait counts; call on the cycle after the PC handshake.
  task automatic serve(input logic [31:0] data, input logic [1:0] resp, input int arw, input int rw,
                       output int lat, output logic [31:0] addr0, output bit ar_ok, output bit pcr_ok);
    int cyc = 1;
    int ac = 0;
    int rc = 0;
    lat = -1;
    ar_ok = 1'b1;
    pcr_ok = 1'b1;
    addr0 = araddr_o;
    while (cyc < 60) begin
      if (inst_valid_o) begin
        lat = cyc;
        break;
      end
      if (pc_ready_o !== 1'b0) pcr_ok = 1'b0;
      arready_i = 1'b0;
      rvalid_i = 1'b0;
      rlast_i = 1'b0;
      if (arvalid_o) begin
        if (araddr_o !== addr0) ar_ok = 1'b0;
        if (ac == arw) arready_i = 1'b1;
        ac++;
      end else if (rready_o) begin
        if (rc == rw) begin
          rvalid_i = 1'b1;
          rlast_i = 1'b1;
          rdata_i = data;
          rresp_i = resp;
        end
        rc++;
      end
      tick();
      cyc++;
    end
    arready_i = 1'b0;
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
  endtask

  // Reference memory seen by the random slave.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f13;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
`ifdef YSYX_23060251_IFU_ERR_EN
    return (a[5:4] == 2'b11) ? 2'b10 : 2'b00;
`else
    return a[5:4];
`endif
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
`ifdef YSYX_23060251_IFU_ERR_EN
    if (resp_of(a) != 2'b00) return 32'h0000_0013;
`endif
    return mem(a);
  endfunction

  int          lat;
  logic [31:0] addr0;
  bit          ar_ok;
  bit          pcr_ok;
  bit          ok;
  logic [31:0] expq [$];
  logic [31:0] epc;
  int          outstanding;
  int          junk;
  int          delivered;
  logic [31:0] r_addr;
  bit          prev_arw;
  logic [31:0] prev_addr;
  bit          prev_hold;
  logic [31:0] prev_inst;
  logic [31:0] prev_ipc;

  initial begin
    vecs[0] = '{pc:32'h8000_0000, data:32'h0010_0093, resp:2'b00, arw:0, rw:0, stall:0,
                lat:3, addr:32'h8000_0000, inst:32'h0010_0093, err:1'b0};
    vecs[1] = '{pc:32'h8000_0010, data:32'h0020_0113, resp:2'b00, arw:3, rw:2, stall:4,
                lat:8, addr:32'h8000_0010, inst:32'h0020_0113, err:1'b0};
    vecs[2] = '{pc:32'h8000_0022, data:32'h1234_5678, resp:2'b00, arw:1, rw:0, stall:1,
                lat:4, addr:32'h8000_0020, inst:32'h1234_5678, err:1'b0};
`ifdef YSYX_23060251_IFU_ERR_EN
    vecs[3] = '{pc:32'h0000_0ffc, data:32'hcafe_f00d, resp:2'b10, arw:0, rw:4, stall:0,
                lat:7, addr:32'h0000_0ffc, inst:32'h0000_0013, err:1'b1};
`else
    vecs[3] = '{pc:32'h0000_0ffc, data:32'hcafe_f00d, resp:2'b10, arw:0, rw:4, stall:0,
                lat:7, addr:32'h0000_0ffc, inst:32'hcafe_f00d, err:1'b0};
`endif
    vecs[4] = '{pc:32'h8000_0004, data:32'h0000_0513, resp:2'b00, arw:2, rw:1, stall:2,
                lat:6, addr:32'h8000_0004, inst:32'h0000_0513, err:1'b0};

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    chk1("rst_pc_ready", pc_ready_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_arvalid", arvalid_o, 1'b0);
    chk1("rst_rready", rready_o, 1'b0);
    chk1("rst_inst_valid", inst_valid_o, 1'b0);
    chk32("rst_inst", inst_o, 32'h0);
    chk32("ar_const", {arid_o, arlen_o, arsize_o, arburst_o, 15'd0}, {4'h0, 8'h00, 3'b010, 2'b01, 15'd0});
    #2 rst_i = 1'b1;
    #1 chk1("rel_pc_ready_pre", pc_ready_o, 1'b0);
    tick();
    chk1("rel_pc_ready_post", pc_ready_o, 1'b1);

    // Latency / data table.
    for (int i = 0; i < 5; i++) begin
      pc_valid_i = 1'b1;
      pc_i = vecs[i].pc;
      #1 chk1($sformatf("v%0d_pc_ready", i), pc_ready_o, 1'b1);
      tick();
      pc_valid_i = 1'b0;
      chk1($sformatf("v%0d_arvalid_c1", i), arvalid_o, 1'b1);
      serve(vecs[i].data, vecs[i].resp, vecs[i].arw, vecs[i].rw, lat, addr0, ar_ok, pcr_ok);
      chk32($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk32($sformatf("v%0d_araddr", i), addr0, vecs[i].addr);
      chk1($sformatf("v%0d_araddr_stable", i), ar_ok, 1'b1);
      chk1($sformatf("v%0d_pc_ready_low", i), pcr_ok, 1'b1);
      chk32($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
      chk32($sformatf("v%0d_inst_pc", i), inst_pc_o, vecs[i].pc);
`ifdef YSYX_23060251_IFU_ERR_EN
      chk1($sformatf("v%0d_err", i), err_o, vecs[i].err);
`endif
      ok = 1'b1;
      for (int k = 0; k < vecs[i].stall; k++) begin
        tick();
        if (inst_o !== vecs[i].inst || inst_pc_o !== vecs[i].pc || inst_valid_o !== 1'b1 ||
            pc_ready_o !== 1'b0) ok = 1'b0;
      end
      chk1($sformatf("v%0d_hold_stable", i), ok, 1'b1);
      consume();
      chk1($sformatf("v%0d_idle_busy", i), busy_o, 1'b0);
      chk1($sformatf("v%0d_idle_valid", i), inst_valid_o, 1'b0);
      chk1($sformatf("v%0d_idle_ready", i), pc_ready_o, 1'b1);
    end

    // Back-to-back: drain OUT and accept the next PC in the same cycle.
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0000;
    tick();
    pc_valid_i = 1'b0;
    serve(32'h0010_0093, 2'b00, 0, 0, lat, addr0, ar_ok, pcr_ok);
    chk32("chain_lat", lat, 3);
    repeat (4) tick();
    chk32("chain_hold_inst", inst_o, 32'h0010_0093);
    inst_ready_i = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0004;
    #1 chk1("chain_pc_ready", pc_ready_o, 1'b1);
    tick();
    inst_ready_i = 1'b0;
    pc_valid_i = 1'b0;
    chk1("chain_arvalid", arvalid_o, 1'b1);
    chk32("chain_araddr", araddr_o, 32'h8000_0004);
    chk1("chain_valid_drop", inst_valid_o, 1'b0);
    serve(32'h00a0_0093, 2'b00, 0, 0, lat, addr0, ar_ok, pcr_ok);
    chk32("chain2_inst", inst_o, 32'h00a0_0093);
    chk32("chain2_inst_pc", inst_pc_o, 32'h8000_0004);
    consume();

    // Flush while AR is waiting: request must persist, reply must vanish.
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0100;
    tick();
    pc_valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk1("flar_arvalid_1", arvalid_o, 1'b1);
    tick();
    chk1("flar_arvalid_2", arvalid_o, 1'b1);
    chk32("flar_araddr", araddr_o, 32'h8000_0100);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    chk1("flar_rready", rready_o, 1'b1);
    rvalid_i = 1'b1;
    rlast_i = 1'b1;
    rdata_i = 32'hdead_beef;
    ok = 1'b0;
    tick();
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (inst_valid_o !== 1'b0) ok = 1'b1;
      tick();
    end
    chk1("flar_no_inst", ok, 1'b0);
    chk1("flar_idle_busy", busy_o, 1'b0);
    chk1("flar_idle_ready", pc_ready_o, 1'b1);
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0104;
    tick();
    pc_valid_i = 1'b0;
    serve(32'h0030_0193, 2'b00, 1, 1, lat, addr0, ar_ok, pcr_ok);
    chk32("flar_next_lat", lat, 5);
    chk32("flar_next_inst", inst_o, 32'h0030_0193);
    consume();

    // Flush on the same cycle as the final beat.
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0200;
    tick();
    pc_valid_i = 1'b0;
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    flush_i = 1'b1;
    rvalid_i = 1'b1;
    rlast_i = 1'b1;
    rdata_i = 32'h1111_1111;
    tick();
    flush_i = 1'b0;
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    chk1("flr_busy", busy_o, 1'b0);
    chk1("flr_valid", inst_valid_o, 1'b0);

    // Flush in OUT.
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0300;
    tick();
    pc_valid_i = 1'b0;
    serve(32'h2222_2222, 2'b00, 0, 0, lat, addr0, ar_ok, pcr_ok);
    chk1("flout_valid_pre", inst_valid_o, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk1("flout_valid", inst_valid_o, 1'b0);
    chk1("flout_busy", busy_o, 1'b0);

    // Flush in IDLE blocks the PC.
    flush_i = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0400;
    #1 chk1("flidle_pc_ready", pc_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    pc_valid_i = 1'b0;
    chk1("flidle_busy", busy_o, 1'b0);
    chk1("flidle_arvalid", arvalid_o, 1'b0);

    // Asynchronous reset while in R.
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0500;
    tick();
    pc_valid_i = 1'b0;
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    chk1("arst_in_r", rready_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk32("arst_outs", {27'd0, pc_ready_o, arvalid_o, rready_o, inst_valid_o, busy_o}, 32'd0);
    chk32("arst_inst", inst_o, 32'h0);
    chk32("arst_inst_pc", inst_pc_o, 32'h0);
    chk32("arst_araddr", araddr_o, 32'h0);
    #3 rst_i = 1'b1;
    #1 chk1("arst_rel_pre", pc_ready_o, 1'b0);
    tick();
    chk1("arst_rel_post", pc_ready_o, 1'b1);

    // Randomized traffic against the queue model.
    outstanding = 0;
    junk = 0;
    delivered = 0;
    prev_arw = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_inst = '0;
    prev_ipc = '0;
    for (int c = 0; c < 3000; c++) begin
      flush_i = ($urandom_range(0, 24) == 0);
      pc_valid_i = 1'($urandom_range(0, 1));
      pc_i = $urandom;
      inst_ready_i = !flush_i && ($urandom_range(0, 2) != 0);
      arready_i = 1'($urandom_range(0, 1));
      rid_i = 4'($urandom_range(0, 15));
      rvalid_i = 1'b0;
      rlast_i = 1'b0;
      rdata_i = $urandom;
      rresp_i = 2'($urandom_range(0, 3));
      if (outstanding != 0 && $urandom_range(0, 1) == 1) begin
        rvalid_i = 1'b1;
        rlast_i = (junk == 0);
        if (rlast_i) begin
          rdata_i = mem(r_addr);
          rresp_i = resp_of(r_addr);
        end
      end
      @(negedge clk_i);
      if (prev_arw) begin
        chk1("rnd_ar_hold", arvalid_o, 1'b1);
        chk32("rnd_ar_addr_hold", araddr_o, prev_addr);
      end
      if (prev_hold) begin
        chk1("rnd_inst_hold_vld", inst_valid_o, 1'b1);
        chk32("rnd_inst_hold", inst_o, prev_inst);
        chk32("rnd_inst_pc_hold", inst_pc_o, prev_ipc);
      end
      if (outstanding != 0 || arvalid_o) chk1("rnd_pc_ready_busy", pc_ready_o, 1'b0);
      if (rvalid_i && rready_o) begin
        if (rlast_i) outstanding = 0;
        else junk--;
      end
      if (arvalid_o && arready_i) begin
        chk32("rnd_single_outstanding", outstanding, 0);
        outstanding = 1;
        r_addr = araddr_o;
        junk = $urandom_range(0, 2);
      end
      if (inst_valid_o && inst_ready_i) begin
        chk1("rnd_inst_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) begin
          epc = expq.pop_front();
          chk32("rnd_inst", inst_o, exp_inst(epc));
          chk32("rnd_inst_pc", inst_pc_o, epc);
`ifdef YSYX_23060251_IFU_ERR_EN
          chk1("rnd_err", err_o, resp_of({epc[31:2], 2'b00}) != 2'b00);
`endif
          delivered++;
        end
      end
      if (flush_i) expq.delete();
      if (pc_valid_i && pc_ready_o) expq.push_back(pc_i);
      prev_arw = arvalid_o && !arready_i;
      prev_addr = araddr_o;
      prev_hold = inst_valid_o && !inst_ready_i && !flush_i;
      prev_inst = inst_o;
      prev_ipc = inst_pc_o;
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b0;
    pc_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    arready_i = 1'b0;
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    chk1("rnd_delivered_enough", delivered > 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
